// File: rtl/lcd_pkg.sv
// Shared LCD pixel-path constants and types: panel geometry, colours and the
// source-mux state encoding.
package lcd_pkg;

   localparam int PIX_W    = 24;
   localparam int COORD_W  = 11;
   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 480;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } mux_state_t;

   localparam logic [PIX_W-1:0] BLACK = 24'h000000;
   localparam logic [PIX_W-1:0] WHITE = 24'hFFFFFF;

endpackage

// File: rtl/lcd_sel_debounce.sv
// Two-flop synchroniser plus stability counter for the DIP-switch source select.
// req_sel only follows the switches after DEB_CYCLES cycles without a change.
module lcd_sel_debounce #(
   parameter int SEL_W      = 2,
   parameter int DEB_CYCLES = 1024,
   parameter int RST_VAL    = 0
) (
   input  logic             clk_in,
   input  logic             sys_rst,
   input  logic [SEL_W-1:0] sel_in,
   output logic [SEL_W-1:0] req_sel
);
   import lcd_pkg::*;

   localparam int               CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
   localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RST_VAL);

   logic [SEL_W-1:0] sync_p0;
   logic [SEL_W-1:0] sync_p1;
   logic [SEL_W-1:0] sel_p2;
   logic [CNT_W-1:0] deb_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // sync_p1 is the synchronised select; sel_p2 is its previous value
   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         sync_p0 <= RST_SEL;
         sync_p1 <= RST_SEL;
         sel_p2  <= RST_SEL;
         deb_cnt <= '0;
         req_sel <= RST_SEL;
      end else begin
         sync_p0 <= sel_in;
         sync_p1 <= sync_p0;
         sel_p2  <= sync_p1;
         if (sync_p1 != sel_p2) begin
            deb_cnt <= '0;
         end else begin
            deb_cnt <= sat_inc(deb_cnt);
            if (deb_cnt == CNT_MAX)
               req_sel <= sync_p1;
         end
      end
   end

endmodule

// File: rtl/lcd_src_mux.sv
// N-way pixel source selector in front of lcd_ctrl; source changes only take
// effect at frame start, optionally separated by whole frames of BLANK_COLOR.
module lcd_src_mux #(
   parameter int               N_SRC        = 2,
   parameter int               SEL_W        = 2,
   parameter int               PIX_W        = lcd_pkg::PIX_W,
   parameter int               COORD_W      = lcd_pkg::COORD_W,
   parameter int               DEB_CYCLES   = 1024,
   parameter int               BLANK_FRAMES = 1,
   parameter logic [PIX_W-1:0] BLANK_COLOR  = PIX_W'(lcd_pkg::BLACK),
   parameter int               DEFAULT_SEL  = 0
) (
   input  logic                   clk_in,
   input  logic                   sys_rst,
   input  logic [SEL_W-1:0]       sel_in,
   input  logic [COORD_W-1:0]     pix_x,
   input  logic [COORD_W-1:0]     pix_y,
   input  logic [N_SRC*PIX_W-1:0] pix_data_in,
   output logic [PIX_W-1:0]       pix_data_out,
   output logic [SEL_W-1:0]       active_sel,
   output logic                   switching,
   output logic                   frame_start
);
   import lcd_pkg::*;

   localparam int               BC_W    = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
   localparam logic [BC_W-1:0]  BC_INIT = BC_W'(BLANK_FRAMES - 1);
   localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);

   logic [SEL_W-1:0] req_sel;
   logic [SEL_W-1:0] next_sel;
   logic             req_ok;
   logic             org_p0;
   logic             org_p1;
   logic             fs_c;
   mux_state_t       state;
   mux_state_t       next_state;
   logic [BC_W-1:0]  blank_cnt;
   logic [BC_W-1:0]  next_bcnt;
   logic [PIX_W-1:0] src_pix;

   // With a single source every request is treated as invalid, so BLANK is unreachable
   function automatic logic sel_valid(input logic [SEL_W-1:0] s);
      return (N_SRC > 1) && (int'(s) < N_SRC);
   endfunction

   lcd_sel_debounce #(
      .SEL_W      (SEL_W),
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (DEFAULT_SEL)
   ) u_sel_debounce (
      .clk_in  (clk_in),
      .sys_rst (sys_rst),
      .sel_in  (sel_in),
      .req_sel (req_sel)
   );

   // Frame start is the first cycle of a run at (0,0); the blanking region may hold it longer
   assign org_p0 = (pix_x == '0) && (pix_y == '0);
   assign fs_c   = org_p0 && !org_p1;
   assign req_ok = sel_valid(req_sel);

   always_comb begin
      next_state = state;
      next_sel   = active_sel;
      next_bcnt  = blank_cnt;
      if (fs_c) begin
         case (state)
            SHOW: begin
               if (req_ok && (req_sel != active_sel)) begin
                  if (BLANK_FRAMES == 0) begin
                     next_sel = req_sel;
                  end else begin
                     next_state = BLANK;
                     next_bcnt  = BC_INIT;
                  end
               end
            end
            BLANK: begin
               // The request seen at exit wins, even if it matches the old source
               if (blank_cnt == '0) begin
                  next_state = SHOW;
                  if (req_ok)
                     next_sel = req_sel;
               end else begin
                  next_bcnt = blank_cnt - BC_W'(1);
               end
            end
            default: next_state = SHOW;
         endcase
      end
   end

   // Select from the post-transition source so pixel (0,0) already shows the new choice
   always_comb begin
      src_pix = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (next_sel == SEL_W'(k))
            src_pix = pix_data_in[k*PIX_W +: PIX_W];
      end
   end

   // p1: registered state, pixel and flags, one cycle after pix_x/pix_y/pix_data_in
   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         state        <= SHOW;
         active_sel   <= DEF_SEL;
         blank_cnt    <= '0;
         org_p1       <= 1'b0;
         pix_data_out <= '0;
         switching    <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         state        <= next_state;
         active_sel   <= next_sel;
         blank_cnt    <= next_bcnt;
         org_p1       <= org_p0;
         pix_data_out <= (next_state == SHOW) ? src_pix : BLANK_COLOR;
         switching    <= (next_state == BLANK);
         frame_start  <= fs_c;
      end
   end

endmodule

// File: tb/tb_lcd_src_mux.sv
// Scoreboard bench: three lcd_src_mux instances with different debounce and
// blank settings share one stimulus and are compared against a cycle model.
module tb_lcd_src_mux;
   localparam int NS        = 3;
   localparam int ND        = 3;
   localparam int FRAME_LEN = 67;

   typedef struct packed {
      logic [23:0] pix;
      logic [1:0]  act;
      logic        sw;
      logic        fs;
   } exp_t;

   logic          clk         = 1'b0;
   logic          sys_rst     = 1'b1;
   logic [1:0]    sel_in      = 2'd0;
   logic [10:0]   pix_x       = '0;
   logic [10:0]   pix_y       = '0;
   logic [NS*24-1:0] pix_data_in = '0;
   logic [23:0]   pix_o [ND];
   logic [1:0]    act_o [ND];
   logic          sw_o  [ND];
   logic          fs_o  [ND];

   logic          rst_v = 1'b1;
   logic [1:0]    sel_v = 2'd0;
   int            pos   = 0;
   logic [23:0]   data_v [NS];
   int            sw_cnt [ND];
   int            sw_total_b = 0;
   int            n_chk = 0;
   int            n_err = 0;
   exp_t          sb_q[$];

   logic [1:0]    m_s1 [ND];
   logic [1:0]    m_s2 [ND];
   logic [1:0]    m_prev [ND];
   logic [1:0]    m_req [ND];
   logic [1:0]    m_act [ND];
   int            m_cnt [ND];
   int            m_left [ND];
   logic          m_blank [ND];
   logic          m_org [ND];

   always #5 clk = ~clk;

   lcd_src_mux #(.N_SRC(3), .SEL_W(2), .PIX_W(24), .COORD_W(11), .DEB_CYCLES(4),
                 .BLANK_FRAMES(1), .BLANK_COLOR(24'h000000), .DEFAULT_SEL(0)) u_a (
      .clk_in(clk), .sys_rst(sys_rst), .sel_in(sel_in), .pix_x(pix_x), .pix_y(pix_y),
      .pix_data_in(pix_data_in), .pix_data_out(pix_o[0]), .active_sel(act_o[0]),
      .switching(sw_o[0]), .frame_start(fs_o[0]));

   lcd_src_mux #(.N_SRC(3), .SEL_W(2), .PIX_W(24), .COORD_W(11), .DEB_CYCLES(8),
                 .BLANK_FRAMES(0), .BLANK_COLOR(24'h000000), .DEFAULT_SEL(0)) u_b (
      .clk_in(clk), .sys_rst(sys_rst), .sel_in(sel_in), .pix_x(pix_x), .pix_y(pix_y),
      .pix_data_in(pix_data_in), .pix_data_out(pix_o[1]), .active_sel(act_o[1]),
      .switching(sw_o[1]), .frame_start(fs_o[1]));

   lcd_src_mux #(.N_SRC(3), .SEL_W(2), .PIX_W(24), .COORD_W(11), .DEB_CYCLES(8),
                 .BLANK_FRAMES(3), .BLANK_COLOR(24'h000000), .DEFAULT_SEL(0)) u_c (
      .clk_in(clk), .sys_rst(sys_rst), .sel_in(sel_in), .pix_x(pix_x), .pix_y(pix_y),
      .pix_data_in(pix_data_in), .pix_data_out(pix_o[2]), .active_sel(act_o[2]),
      .switching(sw_o[2]), .frame_start(fs_o[2]));

   function automatic int deb_of(input int d);
      return (d == 0) ? 4 : 8;
   endfunction

   function automatic int bf_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // Reference behaviour of one instance for the inputs just driven.
   task automatic model_step(input int d, output exp_t e);
      logic       org, fs, blank_n;
      logic [1:0] act_n;
      int         left_n;
      if (rst_v) begin
         m_s1[d] = 2'd0; m_s2[d] = 2'd0; m_prev[d] = 2'd0; m_req[d] = 2'd0;
         m_act[d] = 2'd0; m_cnt[d] = 0; m_left[d] = 0; m_blank[d] = 1'b0; m_org[d] = 1'b0;
         e = '{pix: 24'h0, act: 2'd0, sw: 1'b0, fs: 1'b0};
      end else begin
         org     = (pix_x == 11'd0) && (pix_y == 11'd0);
         fs      = org && !m_org[d];
         act_n   = m_act[d];
         blank_n = m_blank[d];
         left_n  = m_left[d];
         if (fs) begin
            if (!m_blank[d]) begin
               if (m_req[d] < 2'd3 && m_req[d] != m_act[d]) begin
                  if (bf_of(d) == 0) act_n = m_req[d];
                  else begin
                     blank_n = 1'b1;
                     left_n  = bf_of(d);
                  end
               end
            end else begin
               left_n = m_left[d] - 1;
               if (left_n == 0) begin
                  blank_n = 1'b0;
                  if (m_req[d] < 2'd3) act_n = m_req[d];
               end
            end
         end
         e.pix = blank_n ? 24'h0 : data_v[act_n];
         e.act = act_n;
         e.sw  = blank_n;
         e.fs  = fs;
         if (m_s2[d] != m_prev[d]) m_cnt[d] = 0;
         else if (m_cnt[d] < deb_of(d) - 1) m_cnt[d] = m_cnt[d] + 1;
         else m_req[d] = m_s2[d];
         m_prev[d]  = m_s2[d];
         m_s2[d]    = m_s1[d];
         m_s1[d]    = sel_v;
         m_org[d]   = org;
         m_act[d]   = act_n;
         m_blank[d] = blank_n;
         m_left[d]  = left_n;
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (sb_q.size() >= ND) begin
         for (int d = 0; d < ND; d++) begin
            e = sb_q.pop_front();
            check_val($sformatf("pix[%0d]", d), 32'(pix_o[d]), 32'(e.pix));
            check_val($sformatf("active_sel[%0d]", d), 32'(act_o[d]), 32'(e.act));
            check_val($sformatf("switching[%0d]", d), 32'(sw_o[d]), 32'(e.sw));
            check_val($sformatf("frame_start[%0d]", d), 32'(fs_o[d]), 32'(e.fs));
         end
      end
      for (int d = 0; d < ND; d++) sw_cnt[d] += int'(sw_o[d]);
      sw_total_b += int'(sw_o[1]);
      sys_rst = rst_v;
      sel_in  = sel_v;
      if (pos < 4) begin
         pix_x = 11'd0;
         pix_y = 11'd0;
      end else begin
         pix_x = 11'((pos - 3) % 16);
         pix_y = 11'((pos - 3) / 16);
      end
      for (int k = 0; k < NS; k++) begin
         data_v[k] = 24'($urandom);
         pix_data_in[k*24 +: 24] = data_v[k];
      end
      for (int d = 0; d < ND; d++) begin
         model_step(d, e);
         sb_q.push_back(e);
      end
      pos = (pos == FRAME_LEN - 1) ? 0 : pos + 1;
   endtask

   task automatic to_pos(input int target);
      for (int i = 0; i < FRAME_LEN && pos != target; i++) tick();
   endtask

   task automatic clear_counts();
      for (int d = 0; d < ND; d++) sw_cnt[d] = 0;
   endtask

   task automatic check_counts(input string tag, input int ea, input int eb, input int ec);
      check_val({tag, "_blank_a"}, 32'(sw_cnt[0]), 32'(ea));
      check_val({tag, "_blank_b"}, 32'(sw_cnt[1]), 32'(eb));
      check_val({tag, "_blank_c"}, 32'(sw_cnt[2]), 32'(ec));
   endtask

   task automatic check_act(input string tag, input logic [1:0] exp);
      for (int d = 0; d < ND; d++)
         check_val($sformatf("%s_act[%0d]", tag, d), 32'(act_o[d]), 32'(exp));
   endtask

   initial begin
      for (int k = 0; k < NS; k++) data_v[k] = 24'h0;
      clear_counts();

      rst_v = 1'b1;
      sel_v = 2'd1;
      repeat (3) tick();
      for (int d = 0; d < ND; d++) begin
         check_val($sformatf("rst_act[%0d]", d), 32'(act_o[d]), 32'd0);
         check_val($sformatf("rst_pix[%0d]", d), 32'(pix_o[d]), 32'd0);
         check_val($sformatf("rst_sw[%0d]", d), 32'(sw_o[d]), 32'd0);
         check_val($sformatf("rst_fs[%0d]", d), 32'(fs_o[d]), 32'd0);
      end
      rst_v = 1'b0;
      sel_v = 2'd0;
      repeat (2 * FRAME_LEN) tick();

      // short pulse: accepted and withdrawn mid-frame by the fast debouncer, ignored by the slow ones
      to_pos(20);
      clear_counts();
      sel_v = 2'd1;
      repeat (5) tick();
      sel_v = 2'd0;
      repeat (2 * FRAME_LEN) tick();
      check_counts("glitch", 0, 0, 0);
      check_act("glitch", 2'd0);

      to_pos(20);
      clear_counts();
      sel_v = 2'd1;
      repeat (6 * FRAME_LEN) tick();
      check_counts("sw01", FRAME_LEN, 0, 3 * FRAME_LEN);
      check_act("sw01", 2'd1);

      to_pos(20);
      clear_counts();
      sel_v = 2'd2;
      repeat (6 * FRAME_LEN) tick();
      check_counts("sw12", FRAME_LEN, 0, 3 * FRAME_LEN);
      check_act("sw12", 2'd2);

      to_pos(20);
      clear_counts();
      sel_v = 2'd3;
      repeat (3 * FRAME_LEN) tick();
      check_counts("invalid", 0, 0, 0);
      check_act("invalid", 2'd2);

      // reset during the second of three blank frames
      to_pos(20);
      sel_v = 2'd0;
      for (int i = 0; i < 3 * FRAME_LEN && !sw_o[2]; i++) tick();
      check_val("blank_entry_c", 32'(sw_o[2]), 32'd1);
      repeat (FRAME_LEN + 10) tick();
      check_val("mid_blank_c", 32'(sw_o[2]), 32'd1);
      rst_v = 1'b1;
      tick();
      rst_v = 1'b0;
      tick();
      check_val("rst_blank_sw_c", 32'(sw_o[2]), 32'd0);
      check_val("rst_blank_act_c", 32'(act_o[2]), 32'd0);
      check_val("rst_blank_pix_c", 32'(pix_o[2]), 32'd0);
      clear_counts();
      repeat (3 * FRAME_LEN) tick();
      check_val("post_rst_blank_c", 32'(sw_cnt[2]), 32'd0);
      check_val("post_rst_act_c", 32'(act_o[2]), 32'd0);
      check_val("direct_never_blank", 32'(sw_total_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
